fanout_pipe_tree: RTL
=====================

Name: fanout_pipe_tree

Overview:
- Parametrised, registered fanout tree that broadcasts one WIDTH-bit input word to NUM_OUT outputs.
- No register drives more than MAX_FANOUT loads.
- Successor to the flat single-level inverter fanout: adds pipelining, valid tracking, per-output polarity, per-output enable, a global freeze and an accepted-word counter.
- Sits between a high-fanout source and its distributed consumers.

Parameters:
- WIDTH, 1, data width of the broadcast word
- NUM_OUT, 20, number of output channels (>=1)
- MAX_FANOUT, 4, maximum loads per tree register (>=2)
- INV_MASK, {NUM_OUT{1'b0}}, bit i=1 means channel i delivers the bitwise inverse of the input
- CNT_W, 16, width of the accepted-word counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in  input  WIDTH  broadcast data
- in_valid  input  1  in is valid this cycle
- hold  input  1  freeze every tree stage, the output stage and the counter
- out_en  input  NUM_OUT  per-channel update enable, sampled at the output stage
- out  output  NUM_OUT*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- out_valid  output  NUM_OUT  per-channel valid
- acc_cnt  output  CNT_W  count of accepted input words, saturating

Behaviour:
- Reset values:
  - rst=1 clears all tree registers, all valid bits, out, out_valid and acc_cnt to 0 immediately; no clock edge is needed.
  - out is 0 after reset regardless of INV_MASK.
  - Reset mid-stream discards every in-flight word.
- Tree shape:
  - LEVELS is the smallest L>=1 with MAX_FANOUT^L >= NUM_OUT.
  - Stage j (0..LEVELS-1) holds R_j = ceil(NUM_OUT / MAX_FANOUT^(LEVELS-1-j)) registers, each WIDTH data bits plus 1 valid bit.
  - Stage 0 registers load from in/in_valid.
  - Register i of stage j>0 loads from register floor(i/MAX_FANOUT) of stage j-1.
  - Stage LEVELS-1 has exactly NUM_OUT registers and drives out/out_valid.
- Worked example: NUM_OUT=20, MAX_FANOUT=4 gives LEVELS=3 with stage sizes 2, 5, 20.
- Latency:
  - A word presented with in_valid=1 at edge N appears on all enabled channels after edge N+LEVELS-1, i.e. LEVELS cycles of register delay.
  - Throughput is one word per cycle.
- Freeze:
  - When hold=1 at an edge, no register in the design changes: tree, outputs and counter all keep their values.
  - in/in_valid presented during hold are dropped. There is no backpressure.
- Valid propagation: bubbles (in_valid=0) propagate as valid=0 through the tree; tree data registers still load on every non-hold edge.
- Output stage, per channel i, on a non-hold edge:
  - If out_en[i]=1: out_i <= tree_data XOR {WIDTH{INV_MASK[i]}}, and out_valid[i] <= tree_valid.
  - If out_en[i]=0: out_i holds its last value and out_valid[i] <= 0.
  - out_en affects only the output stage; upstream stages keep flowing.
- Counter:
  - acc_cnt increments on each non-hold edge with in_valid=1.
  - It saturates at 2^CNT_W-1 and never wraps.
  - It is cleared only by rst.
- Simultaneous events:
  - rst overrides hold and everything else.
  - hold overrides in_valid and out_en.
- Degenerate case: NUM_OUT=1 gives LEVELS=1, a single register with out_en and inversion applied.
- The design is fully synchronous apart from rst. It has no combinational path from any input to any output.

Test Plan:
- Reset with INV_MASK=0x00001: assert rst mid-stream -> out=0, out_valid=0, acc_cnt=0 asynchronously, with no clock edge.
- Defaults, WIDTH=1, in=1, in_valid=1 for one cycle at edge 0 -> out_valid=20'hFFFFF for exactly the cycle after edge 2, and out=20'hFFFFF in that cycle.
- INV_MASK=20'h00005, WIDTH=8, send 0xA5 -> channels 0 and 2 show 0x5A, all others show 0xA5, all valid after 3 cycles.
- Send 0x11, 0x22, 0x33 back-to-back with out_en[3]=0 during 0x22's output cycle -> channel 3 sequence is 0x11, 0x11 (valid=0), 0x33; channel 4 sequence is 0x11, 0x22, 0x33.
- Stream 0x01..0x05 with hold=1 for 2 cycles while 0x03 is in flight and in_valid=1 -> outputs freeze for 2 cycles, the 2 words presented during hold are dropped, acc_cnt counts only accepted words, ordering is preserved.
- CNT_W=3, send 10 valid words -> acc_cnt saturates at 7.
- NUM_OUT=1, MAX_FANOUT=2 -> latency is 1 cycle; NUM_OUT=16, MAX_FANOUT=4 -> latency is 2 cycles.

Source files
------------

// File: rtl/fanout_pipe_tree.sv
// Registered broadcast tree: one WIDTH-bit word fanned out to NUM_OUT channels,
// no register driving more than MAX_FANOUT loads, with valid tracking and output controls.
module fanout_pipe_tree #(
    parameter int unsigned         WIDTH      = 1,
    parameter int unsigned         NUM_OUT    = 20,
    parameter int unsigned         MAX_FANOUT = 4,
    parameter logic [NUM_OUT-1:0]  INV_MASK   = {NUM_OUT{1'b0}},
    parameter int unsigned         CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           in,
    input  logic                       in_valid,
    input  logic                       hold,
    input  logic [NUM_OUT-1:0]         out_en,
    output logic [NUM_OUT*WIDTH-1:0]   out,
    output logic [NUM_OUT-1:0]         out_valid,
    output logic [CNT_W-1:0]           acc_cnt
);

    // Smallest depth whose full fanout reaches every channel.
    function automatic int unsigned calc_levels(input int unsigned n, input int unsigned mf);
        int unsigned lvl;
        int unsigned reach;
        lvl   = 1;
        reach = mf;
        while (reach < n) begin
            reach = reach * mf;
            lvl   = lvl + 1;
        end
        return lvl;
    endfunction

    function automatic int unsigned stage_size(input int unsigned n, input int unsigned mf,
                                               input int unsigned levels, input int unsigned j);
        int unsigned div;
        div = 1;
        for (int unsigned k = 0; k < levels - 1 - j; k++) begin
            div = div * mf;
        end
        return (n + div - 1) / div;
    endfunction

    function automatic int unsigned stage_off(input int unsigned n, input int unsigned mf,
                                              input int unsigned levels, input int unsigned j);
        int unsigned sum;
        sum = 0;
        for (int unsigned k = 0; k < j; k++) begin
            sum = sum + stage_size(n, mf, levels, k);
        end
        return sum;
    endfunction

    localparam int unsigned LEVELS   = calc_levels(NUM_OUT, MAX_FANOUT);
    localparam int unsigned LEAF_OFF = stage_off(NUM_OUT, MAX_FANOUT, LEVELS, LEVELS - 1);
    localparam int unsigned TOTAL    = LEAF_OFF + NUM_OUT;

    // All stages packed end to end; the last NUM_OUT entries are the output registers.
    logic [TOTAL-1:0][WIDTH-1:0] data_q;
    logic [TOTAL-1:0][WIDTH-1:0] data_d;
    logic [TOTAL-1:0]            valid_q;
    logic [TOTAL-1:0]            valid_d;
    logic [CNT_W-1:0]            cnt_q;
    logic [CNT_W-1:0]            cnt_d;

    for (genvar j = 0; j < int'(LEVELS); j++) begin : g_stage
        localparam int unsigned OFF  = stage_off(NUM_OUT, MAX_FANOUT, LEVELS, j);
        localparam int          SIZE = int'(stage_size(NUM_OUT, MAX_FANOUT, LEVELS, j));

        for (genvar i = 0; i < SIZE; i++) begin : g_reg
            logic [WIDTH-1:0] src_data;
            logic             src_valid;

            if (j == 0) begin : g_root
                assign src_data  = in;
                assign src_valid = in_valid;
            end else begin : g_child
                localparam int unsigned PARENT =
                    stage_off(NUM_OUT, MAX_FANOUT, LEVELS, j - 1) + i / MAX_FANOUT;
                assign src_data  = data_q[PARENT];
                assign src_valid = valid_q[PARENT];
            end

            // Leaf registers apply channel enable and polarity; a disabled channel keeps its data.
            if (j == int'(LEVELS) - 1) begin : g_leaf
                assign data_d[OFF + i]  = out_en[i] ? (src_data ^ {WIDTH{INV_MASK[i]}})
                                                    : data_q[OFF + i];
                assign valid_d[OFF + i] = out_en[i] & src_valid;
            end else begin : g_inner
                assign data_d[OFF + i]  = src_data;
                assign valid_d[OFF + i] = src_valid;
            end
        end
    end

    // Saturating count of words accepted into the tree.
    always_comb begin
        cnt_d = cnt_q;
        if (in_valid && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= '0;
            cnt_q   <= '0;
        end else if (!hold) begin
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out       = data_q[TOTAL-1:LEAF_OFF];
    assign out_valid = valid_q[TOTAL-1:LEAF_OFF];
    assign acc_cnt   = cnt_q;

endmodule
